// File: rtl/rom_multiport.sv
// Shared block-RAM ROM. Several independent read channels share one inferred BRAM read port.
// A round-robin arbiter picks one channel per cycle. Each accepted read carries its channel tag
// down a read pipeline, and the returned word lands in that channel's holding register.
//
// Ports:
//   clka       clock; all state changes on the rising edge
//   rsta       asynchronous, active-high reset
//   ch_req     per-channel read request (level)
//   ch_addr    per-channel address; channel c at [c*AW +: AW]
//   ch_gnt     one-hot grant (combinational); a grant is an accepted read
//   ch_rvalid  one-cycle pulse when the channel's ch_rdata has just been updated
//   ch_rdata   per-channel holding register; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
module rom_multiport #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16384,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned OUT_REG    = 1,
  parameter string       INIT_FILE  = "",
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clka,
  input  logic                         rsta,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*AW-1:0]         ch_addr,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ROM contents start at zero.
  initial begin
    mem = '{default: '0};
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: scan from last_q+1 upward, wrapping, first requester wins.
  // ---------------------------------------------------------------------------
  logic [CHW-1:0]    last_q, last_d;
  logic [CHW-1:0]    scan_idx;
  logic [CHW-1:0]    gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic              accept;

  always_comb begin
    gnt      = '0;
    gnt_idx  = last_q;
    accept   = 1'b0;
    scan_idx = last_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_idx = (scan_idx == CHW'(NUM_CH - 1)) ? '0 : scan_idx + CHW'(1);
      if (!accept && ch_req[scan_idx]) begin
        accept        = 1'b1;
        gnt[scan_idx] = 1'b1;
        gnt_idx       = scan_idx;
      end
    end
    // No reads are accepted while reset is held.
    if (rsta) begin
      gnt    = '0;
      accept = 1'b0;
    end
  end

  assign ch_gnt = gnt;
  assign last_d = accept ? gnt_idx : last_q;

  // Address of the granted channel.
  logic [AW-1:0] rd_addr;
  logic          in_range;

  always_comb begin
    rd_addr = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        rd_addr = ch_addr[c*AW +: AW];
      end
    end
  end

  // Only matters when DEPTH is not a power of two.
  assign in_range = (32'(rd_addr) < DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: BRAM data register plus tag/valid sideband.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] bram_q;
  logic                  s1_vld_q;
  logic [CHW-1:0]        s1_tag_q;
  logic                  s1_oor_q;
  logic [DATA_WIDTH-1:0] s1_data;

  // The BRAM register has no reset so it maps onto the block RAM output latch.
  always_ff @(posedge clka) begin
    if (accept && in_range) begin
      bram_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      last_q   <= CHW'(NUM_CH - 1);
      s1_vld_q <= 1'b0;
      s1_tag_q <= '0;
      s1_oor_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      s1_vld_q <= accept;
      if (accept) begin
        s1_tag_q <= gnt_idx;
        s1_oor_q <= !in_range;
      end
    end
  end

  // Out-of-range reads return zero rather than whatever the BRAM last held.
  assign s1_data = s1_oor_q ? '0 : bram_q;

  // ---------------------------------------------------------------------------
  // Optional output register stage.
  // ---------------------------------------------------------------------------
  logic                  out_vld;
  logic [CHW-1:0]        out_tag;
  logic [DATA_WIDTH-1:0] out_data;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_vld_q;
    logic [CHW-1:0]        s2_tag_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
        s2_vld_q  <= 1'b0;
        s2_tag_q  <= '0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_tag_q  <= s1_tag_q;
          s2_data_q <= s1_data;
        end
      end
    end

    assign out_vld  = s2_vld_q;
    assign out_tag  = s2_tag_q;
    assign out_data = s2_data_q;
  end else begin : g_no_out_reg
    assign out_vld  = s1_vld_q;
    assign out_tag  = s1_tag_q;
    assign out_data = s1_data;
  end

  // ---------------------------------------------------------------------------
  // Channel stage: steer the returning word to its channel's holding register.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]            out_hit;
  logic [NUM_CH-1:0]            rvalid_q;
  logic [NUM_CH*DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    out_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      out_hit[c] = out_vld && (out_tag == CHW'(c));
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= out_hit;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (out_hit[c]) begin
          rdata_q[c*DATA_WIDTH +: DATA_WIDTH] <= out_data;
        end
      end
    end
  end

  assign ch_rvalid = rvalid_q;
  assign ch_rdata  = rdata_q;

endmodule

// File: tb/tb_rom_multiport.sv
// Bench for rom_multiport with two instances:
//   dut_a: NUM_CH=2, OUT_REG=1, DEPTH=16384, image word[a] = a[7:0]
//   dut_b: NUM_CH=3, OUT_REG=0, DEPTH=12000, image word[a] = (7*a+3)[7:0]
// A reference model checks every output on every falling edge. Literal checks pin
// the model to hand-computed values.
module tb_rom_multiport;

  logic        clk;
  logic        a_rst, b_rst;
  logic [1:0]  a_req, a_gnt, a_rv;
  logic [13:0] a_ad0, a_ad1;
  logic [27:0] a_addr;
  logic [15:0] a_rd;
  logic [2:0]  b_req, b_gnt, b_rv;
  logic [13:0] b_ad0, b_ad1, b_ad2;
  logic [41:0] b_addr;
  logic [23:0] b_rd;

  assign a_addr = {a_ad1, a_ad0};
  assign b_addr = {b_ad2, b_ad1, b_ad0};

  rom_multiport #(
    .DATA_WIDTH(8),
    .DEPTH     (16384),
    .NUM_CH    (2),
    .OUT_REG   (1),
    .INIT_FILE ("")
  ) dut_a (
    .clka     (clk),
    .rsta     (a_rst),
    .ch_req   (a_req),
    .ch_addr  (a_addr),
    .ch_gnt   (a_gnt),
    .ch_rvalid(a_rv),
    .ch_rdata (a_rd)
  );

  rom_multiport #(
    .DATA_WIDTH(8),
    .DEPTH     (12000),
    .NUM_CH    (3),
    .OUT_REG   (0),
    .INIT_FILE ("")
  ) dut_b (
    .clka     (clk),
    .rsta     (b_rst),
    .ch_req   (b_req),
    .ch_addr  (b_addr),
    .ch_gnt   (b_gnt),
    .ch_rvalid(b_rv),
    .ch_rdata (b_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int rom_word(input int k, input int a);
    if (k == 0) return a % 256;
    if (a >= 12000) return 0;
    return (a * 7 + 3) % 256;
  endfunction

  function automatic int req_bit(input int k, input int c);
    if (k == 0) return int'((a_req >> c) & 2'b01);
    return int'((b_req >> c) & 3'b001);
  endfunction

  function automatic int gnt_bit(input int k, input int c);
    if (k == 0) return int'((a_gnt >> c) & 2'b01);
    return int'((b_gnt >> c) & 3'b001);
  endfunction

  function automatic int rv_bit(input int k, input int c);
    if (k == 0) return int'((a_rv >> c) & 2'b01);
    return int'((b_rv >> c) & 3'b001);
  endfunction

  function automatic int rd_byte(input int k, input int c);
    if (k == 0) return int'((a_rd >> (8 * c)) & 16'h00ff);
    return int'((b_rd >> (8 * c)) & 24'h0000ff);
  endfunction

  function automatic int addr_of(input int k, input int c);
    if (k == 0) return int'((c == 0) ? a_ad0 : a_ad1);
    if (c == 0) return int'(b_ad0);
    if (c == 1) return int'(b_ad1);
    return int'(b_ad2);
  endfunction

  // Per instance: round-robin pointer, expected outputs and a time wheel of
  // responses keyed by the edge number at which they land in ch_rdata.
  int m_last [2];
  int m_rd   [2][3];
  int m_rv   [2][3];
  int cyc    [2];
  int sv     [2][8];
  int sch    [2][8];
  int sd     [2][8];

  // Compare the current outputs, then advance the model across the coming rising edge.
  task automatic check_inst(input int k);
    int nch, lat, rst, eg, c, slot, due;
    nch = (k == 0) ? 2 : 3;
    lat = (k == 0) ? 2 : 1;  // edges after the accept edge until ch_rdata updates
    rst = (k == 0) ? int'(a_rst) : int'(b_rst);
    if (rst != 0) begin
      m_last[k] = nch - 1;
      for (int j = 0; j < 3; j++) begin
        m_rd[k][j] = 0;
        m_rv[k][j] = 0;
      end
      for (int s = 0; s < 8; s++) sv[k][s] = 0;
    end
    eg = -1;
    if (rst == 0) begin
      for (int i = 1; i <= nch; i++) begin
        c = (m_last[k] + i) % nch;
        if (eg < 0 && req_bit(k, c) != 0) eg = c;
      end
    end
    for (int j = 0; j < nch; j++) begin
      chk($sformatf("inst%0d gnt[%0d]", k, j), gnt_bit(k, j), (j == eg) ? 1 : 0);
      chk($sformatf("inst%0d rvalid[%0d]", k, j), rv_bit(k, j), m_rv[k][j]);
      chk($sformatf("inst%0d rdata[%0d]", k, j), rd_byte(k, j), m_rd[k][j]);
    end
    if (rst == 0) begin
      cyc[k]++;
      slot = cyc[k] % 8;
      for (int j = 0; j < 3; j++) m_rv[k][j] = 0;
      if (sv[k][slot] != 0) begin
        m_rv[k][sch[k][slot]] = 1;
        m_rd[k][sch[k][slot]] = sd[k][slot];
        sv[k][slot] = 0;
      end
      if (eg >= 0) begin
        m_last[k]     = eg;
        due           = (cyc[k] + lat) % 8;
        sv[k][due]    = 1;
        sch[k][due]   = eg;
        sd[k][due]    = rom_word(k, addr_of(k, eg));
      end
    end
  endtask

  always @(negedge clk) begin
    check_inst(0);
    check_inst(1);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int t3 [4] = '{191, 198, 205, 212};
  int tw;
  int cnt;

  initial begin
    a_rst = 1'b1;
    b_rst = 1'b1;
    a_req = 2'b11;  // requests during reset must not be granted
    b_req = 3'b111;
    a_ad0 = '0;
    a_ad1 = '0;
    b_ad0 = '0;
    b_ad1 = '0;
    b_ad2 = '0;
    #1;
    for (int i = 0; i < 16384; i++) dut_a.mem[i[13:0]] = i[7:0];
    for (int i = 0; i < 12000; i++) begin
      tw = i * 7 + 3;
      dut_b.mem[i[13:0]] = tw[7:0];
    end

    // Reset state
    at_neg();
    chk("reset a_gnt", int'(a_gnt), 0);
    chk("reset b_gnt", int'(b_gnt), 0);
    chk("reset a_rvalid", int'(a_rv), 0);
    chk("reset a_rdata", int'(a_rd), 0);
    chk("reset b_rdata", int'(b_rd), 0);

    // 1: single ch0 read of 0x0123 on the OUT_REG=1 instance
    tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    b_req = 3'b000;
    a_req = 2'b01;
    a_ad0 = 14'h0123;
    at_neg();
    chk("t1 gnt", int'(a_gnt), 1);
    tick();
    a_req = 2'b00;
    at_neg();
    chk("t1 rvalid E0", int'(a_rv), 0);
    tick();
    at_neg();
    chk("t1 rvalid E0+1", int'(a_rv), 0);
    tick();
    at_neg();
    chk("t1 rvalid E0+2", int'(a_rv), 1);
    chk("t1 rdata", int'(a_rd), 16'h0023);
    tick();
    at_neg();
    chk("t1 rvalid pulse end", int'(a_rv), 0);

    // 2: both channels request continuously from reset
    tick();
    a_rst = 1'b1;
    at_neg();
    tick();
    a_rst = 1'b0;
    a_req = 2'b11;
    a_ad0 = 14'h0010;
    a_ad1 = 14'h0281;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      chk($sformatf("t2 gnt %0d", i), int'(a_gnt), (i % 2 == 0) ? 1 : 2);
      tick();
      if (i % 2 == 0) a_ad0 = a_ad0 + 14'd1;
      else a_ad1 = a_ad1 + 14'd1;
    end
    a_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      tick();
    end
    at_neg();
    chk("t2 rdata", int'(a_rd), 16'h8413);

    // 3: only ch2 of the 3-channel instance, 4 back-to-back reads
    tick();
    b_req = 3'b100;
    b_ad2 = 14'd100;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk($sformatf("t3 gnt %0d", i), int'(b_gnt), 4);
      if (i >= 2) begin
        chk($sformatf("t3 rvalid %0d", i), int'(b_rv), 4);
        chk($sformatf("t3 rdata %0d", i), int'(b_rd >> 16), t3[i-2]);
      end
      tick();
      b_ad2 = b_ad2 + 14'd1;
    end
    b_req = 3'b000;
    at_neg();
    chk("t3 rvalid 4", int'(b_rv), 4);
    chk("t3 rdata 4", int'(b_rd >> 16), t3[2]);
    tick();
    at_neg();
    chk("t3 rvalid 5", int'(b_rv), 4);
    chk("t3 rdata 5", int'(b_rd >> 16), t3[3]);
    tick();
    at_neg();
    chk("t3 rvalid end", int'(b_rv), 0);

    // 3b: all three request, rotation continues from last=2
    tick();
    b_req = 3'b111;
    b_ad0 = 14'd1;
    b_ad1 = 14'd2;
    b_ad2 = 14'd3;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk($sformatf("t3b gnt %0d", i), int'(b_gnt), 1 << (i % 3));
      tick();
    end
    b_req = 3'b000;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      tick();
    end

    // 4: reset one cycle after a ch1 accept drops the read
    a_req = 2'b10;
    a_ad1 = 14'h0055;
    at_neg();
    chk("t4 gnt ch1", int'(a_gnt), 2);
    tick();
    a_req = 2'b00;
    at_neg();
    tick();
    a_rst = 1'b1;
    at_neg();
    chk("t4 rvalid in reset", int'(a_rv), 0);
    chk("t4 rdata in reset", int'(a_rd), 0);
    tick();
    a_rst = 1'b0;
    a_req = 2'b11;
    a_ad0 = 14'h0031;
    a_ad1 = 14'h0042;
    at_neg();
    chk("t4 gnt after reset", int'(a_gnt), 1);
    tick();
    a_req = 2'b00;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      if (a_rv[1]) cnt++;
      tick();
    end
    at_neg();
    chk("t4 no rvalid1", cnt, 0);
    chk("t4 rdata", int'(a_rd), 16'h0031);

    // 6: ch1 drops its request before being granted
    cnt = 0;
    tick();
    a_req = 2'b10;
    a_ad1 = 14'h0077;
    at_neg();
    chk("t6 gnt ch1", int'(a_gnt), 2);
    if (a_rv[1]) cnt++;
    tick();
    a_req = 2'b11;
    a_ad0 = 14'h000A;
    a_ad1 = 14'h0099;
    at_neg();
    chk("t6 gnt ch0 over ch1", int'(a_gnt), 1);
    if (a_rv[1]) cnt++;
    tick();
    a_req = 2'b01;
    a_ad0 = 14'h000B;
    at_neg();
    chk("t6 gnt ch0 again", int'(a_gnt), 1);
    if (a_rv[1]) cnt++;
    tick();
    a_req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      if (a_rv[1]) cnt++;
      tick();
    end
    at_neg();
    chk("t6 rvalid1 count", cnt, 1);
    chk("t6 rdata", int'(a_rd), 16'h770B);

    // 5: OUT_REG=0 latency and out-of-range addresses on the DEPTH=12000 instance
    tick();
    b_req = 3'b001;
    b_ad0 = 14'h0123;
    at_neg();
    chk("t5 gnt", int'(b_gnt), 1);
    tick();
    b_ad0 = 14'd11999;
    at_neg();
    chk("t5 rvalid E0", int'(b_rv), 0);
    tick();
    b_ad0 = 14'd12000;
    at_neg();
    chk("t5 rvalid E0+1", int'(b_rv), 1);
    chk("t5 rdata 0x123", int'(b_rd & 24'hff), 8'hF8);
    tick();
    b_ad0 = 14'd16383;
    at_neg();
    chk("t5 rdata 11999", int'(b_rd & 24'hff), 8'h1C);
    tick();
    b_req = 3'b000;
    at_neg();
    chk("t5 rvalid 12000", int'(b_rv), 1);
    chk("t5 rdata 12000", int'(b_rd & 24'hff), 0);
    tick();
    at_neg();
    chk("t5 rvalid 16383", int'(b_rv), 1);
    chk("t5 rdata 16383", int'(b_rd & 24'hff), 0);
    tick();
    at_neg();
    chk("t5 rvalid end", int'(b_rv), 0);

    tick();
    at_neg();
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
